imem_boot_sequencer: RTL and testbench

- Boot/run controller in front of the five-stage RISC-V core.
- Accepts a program as a stream of 32-bit words over a valid/ready handshake and writes it into instruction memory through the memory's external port.
- Optionally reads the image back and checks a wrap-around checksum, then drives the core's enable for a programmed cycle budget.
- Reports done or error. Sits between the testbench/host and the core's external instruction-memory port and enable input.

---
 rtl/imem_boot_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_sequencer.sv
// Boot/run controller: streams a program into instruction memory, optionally
// verifies it by readback checksum, then gates the core enable for a cycle budget.
module imem_boot_sequencer #(
    parameter int MAX_WORDS = 512,
    parameter int IDX_W     = 9,
    parameter bit VERIFY_EN = 1'b1,
    parameter int CYC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic             stop,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    input  logic             word_last,
    output logic             word_ready,
    output logic [63:0]      imem_addr_ext,
    output logic             imem_wen_ext,
    output logic             imem_ren_ext,
    output logic [31:0]      imem_wdata_ext,
    input  logic [31:0]      imem_rdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_WORDS - 1);
    localparam logic [IDX_W:0]   WL_ONE   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W:0]     rd_idx_r;
    logic [31:0]        load_sum_r;
    logic [31:0]        read_sum_r;
    logic [CYC_W-1:0]   budget_r;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic               rd_valid_r;
    logic               load_drain_r;
    logic               accept_s;
    logic               last_word_s;

    // Wrap-around 32-bit checksum accumulation shared by load and readback.
    function automatic logic [31:0] sum_add(input logic [31:0] acc, input logic [31:0] word);
        return acc + word;
    endfunction

    // Word index to zero-extended byte address.
    function automatic logic [63:0] word_addr(input logic [IDX_W-1:0] i);
        return {{(64-IDX_W-2){1'b0}}, i, 2'b00};
    endfunction

    assign accept_s    = word_valid & word_ready;
    assign last_word_s = word_last | (idx_r == IDX_LAST);

    // Sequencer state, counters, checksums and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            idx_r          <= '0;
            rd_idx_r       <= '0;
            load_sum_r     <= 32'h0000_0000;
            read_sum_r     <= 32'h0000_0000;
            budget_r       <= CYC_ZERO;
            cyc_cnt_r      <= CYC_ZERO;
            rd_valid_r     <= 1'b0;
            load_drain_r   <= 1'b0;
            word_ready     <= 1'b0;
            imem_addr_ext  <= 64'h0;
            imem_wen_ext   <= 1'b0;
            imem_ren_ext   <= 1'b0;
            imem_wdata_ext <= 32'h0000_0000;
            cpu_enable     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
        end else begin
            imem_wen_ext   <= 1'b0;
            imem_ren_ext   <= 1'b0;
            imem_addr_ext  <= 64'h0;
            imem_wdata_ext <= 32'h0000_0000;
            rd_valid_r     <= imem_ren_ext;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_r      <= ST_LOAD;
                        idx_r        <= '0;
                        rd_idx_r     <= '0;
                        load_sum_r   <= 32'h0000_0000;
                        read_sum_r   <= 32'h0000_0000;
                        words_loaded <= '0;
                        budget_r     <= run_cycles;
                        cyc_cnt_r    <= CYC_ZERO;
                        load_drain_r <= 1'b0;
                        word_ready   <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_enable   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Without verify, wait one cycle so the final write lands before the core fetches.
                    if (load_drain_r) begin
                        load_drain_r <= 1'b0;
                        state_r      <= ST_RUN;
                        cpu_enable   <= 1'b1;
                    end else if (accept_s) begin
                        imem_wen_ext   <= 1'b1;
                        imem_addr_ext  <= word_addr(idx_r);
                        imem_wdata_ext <= word_data;
                        idx_r          <= idx_r + IDX_ONE;
                        words_loaded   <= words_loaded + WL_ONE;
                        load_sum_r     <= sum_add(load_sum_r, word_data);
                        if (last_word_s) begin
                            word_ready <= 1'b0;
                            if (VERIFY_EN) begin
                                state_r <= ST_VERIFY;
                            end else begin
                                load_drain_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_VERIFY: begin
                    if (rd_valid_r) begin
                        read_sum_r <= sum_add(read_sum_r, imem_rdata_ext);
                    end
                    if (rd_idx_r != words_loaded) begin
                        imem_ren_ext  <= 1'b1;
                        imem_addr_ext <= word_addr(rd_idx_r[IDX_W-1:0]);
                        rd_idx_r      <= rd_idx_r + WL_ONE;
                    end else if (!imem_ren_ext && !rd_valid_r) begin
                        // Every read issued and absorbed: read_sum is final.
                        if (read_sum_r == load_sum_r) begin
                            state_r    <= ST_RUN;
                            cpu_enable <= 1'b1;
                        end else begin
                            state_r <= ST_ERROR;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop || ((budget_r != CYC_ZERO) && (cyc_cnt_r == budget_r - CYC_ONE))) begin
                        state_r    <= ST_DONE;
                        cpu_enable <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    word_ready <= 1'b0;
                    cpu_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer: one verifying instance with a memory
// model (A) and one non-verifying instance (B) sharing clock, reset and stream.
module tb_imem_boot_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, stop, word_valid, word_last, corrupt;
    logic [31:0] run_cycles, word_data;

    logic        ready_a, wen_a, ren_a, en_a, busy_a, done_a, error_a;
    logic [63:0] addr_a;
    logic [31:0] wdata_a, rdata_a;
    logic [9:0]  wl_a;

    logic        ready_b, wen_b, ren_b, en_b, busy_b, done_b, error_b;
    logic [63:0] addr_b;
    logic [31:0] wdata_b;
    logic [9:0]  wl_b;

    int checks = 0;
    int failures = 0;
    int wen_cnt, ren_cnt, en_cnt, both_cnt, hold_cnt;

    logic [31:0] prog    [0:511];
    logic [63:0] wen_log [0:511];
    logic [31:0] mem     [0:511];
    logic [31:0] rd_q;
    logic [8:0]  rd_word_q;

    imem_boot_sequencer #(.MAX_WORDS(512), .IDX_W(9), .VERIFY_EN(1'b1), .CYC_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .run_cycles(run_cycles), .stop(stop),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(ready_a), .imem_addr_ext(addr_a), .imem_wen_ext(wen_a),
        .imem_ren_ext(ren_a), .imem_wdata_ext(wdata_a), .imem_rdata_ext(rdata_a),
        .cpu_enable(en_a), .busy(busy_a), .done(done_a), .error(error_a),
        .words_loaded(wl_a)
    );

    imem_boot_sequencer #(.MAX_WORDS(512), .IDX_W(9), .VERIFY_EN(1'b0), .CYC_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .run_cycles(run_cycles), .stop(stop),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(ready_b), .imem_addr_ext(addr_b), .imem_wen_ext(wen_b),
        .imem_ren_ext(ren_b), .imem_wdata_ext(wdata_b), .imem_rdata_ext(32'h0000_0000),
        .cpu_enable(en_b), .busy(busy_b), .done(done_b), .error(error_b),
        .words_loaded(wl_b)
    );

    // Instruction memory model for instance A: registered read, optional bit-0 corruption of word 1.
    always @(posedge clk) begin
        if (wen_a) mem[addr_a[10:2]] <= wdata_a;
        if (ren_a) begin
            rd_q      <= mem[addr_a[10:2]];
            rd_word_q <= addr_a[10:2];
        end
    end
    assign rdata_a = rd_q ^ {31'd0, (corrupt && (rd_word_q == 9'd1))};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present n words from prog[] back to back; logs each write seen on A.
    task automatic stream(input int n, input bit use_last);
        wen_cnt = 0;
        for (int i = 0; i < n; i++) begin
            word_valid = 1'b1;
            word_data  = prog[i];
            word_last  = use_last && (i == n - 1);
            tick();
            if (wen_a) begin
                wen_log[wen_cnt] = addr_a;
                wen_cnt++;
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_data  = 32'h0000_0000;
    endtask

    // Advance until A reaches DONE or ERROR, counting reads, enable cycles and port overlaps.
    task automatic run_to_end(input int bound);
        ren_cnt = 0; en_cnt = 0; both_cnt = 0;
        for (int k = 0; k < bound && !(done_a || error_a); k++) begin
            tick();
            if (ren_a) ren_cnt++;
            if (en_a) en_cnt++;
            if (ren_a && wen_a) both_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; stop = 1'b0; corrupt = 1'b0;
        word_valid = 1'b0; word_last = 1'b0; word_data = 32'h0; run_cycles = 32'd0;
        rd_q = 32'h0; rd_word_q = 9'd0;
        prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0020_8113;

        // 1: reset with start held
        tick(); tick();
        chk("rst_ready",   64'(ready_a), 64'd0);
        chk("rst_busy",    64'(busy_a),  64'd0);
        chk("rst_flags",   64'({done_a, error_a, en_a, wen_a, ren_a}), 64'd0);
        chk("rst_addr",    addr_a, 64'd0);
        chk("rst_wl",      64'(wl_a), 64'd0);
        chk("rst_b_flags", 64'({ready_b, busy_b, done_b, error_b, en_b}), 64'd0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tick();

        // 2: three-word load, verify, run 10 cycles
        run_cycles = 32'd10; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("load_ready", 64'(ready_a), 64'd1);
        chk("load_busy",  64'(busy_a),  64'd1);
        stream(3, 1'b1);
        chk("t2_wen_cnt", 64'(wen_cnt), 64'd3);
        chk("t2_addr0",   wen_log[0], 64'h0);
        chk("t2_addr1",   wen_log[1], 64'h4);
        chk("t2_addr2",   wen_log[2], 64'h8);
        chk("t2_ready_drop", 64'(ready_a), 64'd0);
        run_to_end(100);
        chk("t2_mem1",  64'(mem[1]), 64'h0010_0093);
        chk("t2_reads", 64'(ren_cnt), 64'd3);
        chk("t2_en_cycles", 64'(en_cnt), 64'd10);
        chk("t2_overlap", 64'(both_cnt), 64'd0);
        chk("t2_done",  64'(done_a), 64'd1);
        chk("t2_error", 64'(error_a), 64'd0);
        chk("t2_wl",    64'(wl_a), 64'd3);
        tick();
        chk("t2_done_hold", 64'({done_a, en_a, busy_a}), 64'b100);

        // 3: corrupted readback of word 1 -> ERROR
        corrupt = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        stream(3, 1'b1);
        run_to_end(100);
        chk("t3_error",  64'(error_a), 64'd1);
        chk("t3_done",   64'(done_a), 64'd0);
        chk("t3_no_en",  64'(en_cnt), 64'd0);
        chk("t3_busy",   64'(busy_a), 64'd0);
        chk("t3_wl",     64'(wl_a), 64'd3);
        corrupt = 1'b0;
        for (int i = 0; i < 512; i++) prog[i] = 32'(i) * 32'h9E37_79B9 + 32'h0000_0013;
        run_cycles = 32'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t3_restart_err", 64'(error_a), 64'd0);
        chk("t3_restart_rdy", 64'(ready_a), 64'd1);
        chk("t3_restart_wl",  64'(wl_a), 64'd0);

        // 5: full 512-word load with no word_last
        stream(512, 1'b0);
        chk("t5_wen_cnt",   64'(wen_cnt), 64'd512);
        chk("t5_last_addr", wen_log[511], 64'h7FC);
        chk("t5_ready_drop", 64'(ready_a), 64'd0);
        chk("t5_wl",        64'(wl_a), 64'd512);
        run_to_end(700);
        chk("t5_reads",  64'(ren_cnt), 64'd512);
        chk("t5_en",     64'(en_cnt), 64'd2);
        chk("t5_done",   64'({done_a, error_a}), 64'b10);
        chk("t5_overlap", 64'(both_cnt), 64'd0);

        // 4: no verify, unbounded run, stop pulse
        run_cycles = 32'd0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("t4_ready", 64'(ready_b), 64'd1);
        word_valid = 1'b1; word_data = 32'h0000_0013; word_last = 1'b1;
        tick();
        word_valid = 1'b0; word_last = 1'b0;
        chk("t4_wen",     64'({wen_b, ready_b, en_b}), 64'b100);
        chk("t4_wr_addr", addr_b, 64'h0);
        tick();
        chk("t4_en_start", 64'({en_b, busy_b}), 64'b11);
        hold_cnt = 0;
        for (int k = 0; k < 999; k++) begin
            tick();
            if (en_b) hold_cnt++;
        end
        chk("t4_en_hold", 64'(hold_cnt), 64'd999);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_en",  64'(en_b), 64'd0);
        chk("t4_done",     64'({done_b, error_b, busy_b}), 64'b100);
        chk("t4_wl",       64'(wl_b), 64'd1);
        chk("t4_a_undisturbed", 64'(done_a), 64'd1);

        // 6: reset mid-load, then a clean 8-word load
        run_cycles = 32'd3; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        stream(5, 1'b0);
        chk("t6_wl_partial", 64'(wl_a), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_flags", 64'({busy_a, ready_a, wen_a, done_a, en_a}), 64'd0);
        chk("t6_rst_wl",    64'(wl_a), 64'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        stream(8, 1'b1);
        chk("t6_last_addr", wen_log[7], 64'h1C);
        run_to_end(100);
        chk("t6_reads", 64'(ren_cnt), 64'd8);
        chk("t6_en",    64'(en_cnt), 64'd3);
        chk("t6_done",  64'({done_a, error_a}), 64'b10);
        chk("t6_wl",    64'(wl_a), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
